// File: rtl/vivo_pop_arbiter.sv
// Round-robin arbiter sharing one vivo_fifo pop port between NUM_CONS consumers.
// Optional perf counters are enabled with the VIVO_POP_ARB_PERF_EN macro.
module vivo_pop_arbiter #(
  parameter int NUM_CONS      = 4,
  parameter int ELEM_WIDTH    = 8,
  parameter int OUT_ELEMS_MAX = 4,
  parameter int CNT_W         = 16,
  localparam int EW = $clog2(OUT_ELEMS_MAX + 1),
  localparam int PW = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_CONS-1:0]                      c_req,
  input  logic [NUM_CONS-1:0][EW-1:0]              c_req_elems,
  output logic [NUM_CONS-1:0]                      c_grant,
  output logic [NUM_CONS-1:0]                      c_valid,
  input  logic [NUM_CONS-1:0]                      c_ready,
  output logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] c_data,
  output logic [EW-1:0]                            c_num_elems,
  output logic [EW-1:0]                            f_req_elems,
  output logic                                     f_out_ready,
  input  logic                                     f_out_valid,
  input  logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] f_out_data,
  input  logic [EW-1:0]                            f_out_num_elems,
  output logic                                     busy
`ifdef VIVO_POP_ARB_PERF_EN
  ,
  input  logic                                     perf_clr,
  output logic [NUM_CONS-1:0][CNT_W-1:0]           perf_elems,
  output logic [CNT_W-1:0]                         perf_stall
`endif
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [PW-1:0]         rr_ptr_r, rr_ptr_s;
  logic [PW-1:0]         g_idx_r, g_idx_s;
  logic [EW-1:0]         g_elems_r, g_elems_s;
  logic [NUM_CONS-1:0]   grant_r, grant_s;
  logic [NUM_CONS-1:0]   elig_s;
  logic [PW-1:0]         idx_s;
  logic [PW-1:0]         sel_s;
  logic                  found_s;
  logic                  hs_s;

  // Eligibility: requesting with an in-range element count
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_CONS; i++) begin
      elig_s[i] = c_req[i] && (c_req_elems[i] != {EW{1'b0}}) &&
                  (c_req_elems[i] <= EW'(OUT_ELEMS_MAX));
    end
  end

  // Round-robin scan starting at rr_ptr
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CONS; k++) begin
      idx_s = PW'((int'(rr_ptr_r) + k) % NUM_CONS);
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  assign hs_s = (state_r == ST_ISSUE) && f_out_valid && c_ready[g_idx_r];

  // Next-state logic; g_elems is zeroed outside ISSUE so f_req_elems reads 0 in ARB
  always_comb begin
    state_s   = state_r;
    rr_ptr_s  = rr_ptr_r;
    g_idx_s   = g_idx_r;
    g_elems_s = g_elems_r;
    grant_s   = grant_r;
    case (state_r)
      ST_ARB: begin
        if (found_s) begin
          state_s   = ST_ISSUE;
          g_idx_s   = sel_s;
          g_elems_s = c_req_elems[sel_s];
          grant_s   = NUM_CONS'(1) << sel_s;
        end else begin
          state_s   = ST_ARB;
        end
      end
      ST_ISSUE: begin
        if (hs_s) begin
          state_s   = ST_ARB;
          rr_ptr_s  = PW'((int'(g_idx_r) + 1) % NUM_CONS);
          g_elems_s = '0;
          grant_s   = '0;
        end else begin
          state_s   = ST_ISSUE;
        end
      end
      default: begin
        state_s   = ST_ARB;
        g_elems_s = '0;
        grant_s   = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ARB;
      rr_ptr_r  <= '0;
      g_idx_r   <= '0;
      g_elems_r <= '0;
      grant_r   <= '0;
    end else begin
      state_r   <= state_s;
      rr_ptr_r  <= rr_ptr_s;
      g_idx_r   <= g_idx_s;
      g_elems_r <= g_elems_s;
      grant_r   <= grant_s;
    end
  end

  // Valid is steered only to the granted consumer
  always_comb begin
    c_valid = '0;
    if (state_r == ST_ISSUE) begin
      c_valid[g_idx_r] = f_out_valid;
    end else begin
      c_valid = '0;
    end
  end

  assign c_grant     = grant_r;
  assign f_req_elems = g_elems_r;
  assign f_out_ready = hs_s;
  assign busy        = (state_r == ST_ISSUE);
  assign c_data      = f_out_data;
  assign c_num_elems = f_out_num_elems;

`ifdef VIVO_POP_ARB_PERF_EN
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Saturating perf counters; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_elems <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_elems <= '0;
      perf_stall <= '0;
    end else begin
      if (hs_s) begin
        perf_elems[g_idx_r] <= sat_add(perf_elems[g_idx_r], CNT_W'(f_out_num_elems));
      end else begin
        perf_elems <= perf_elems;
      end
      if ((state_r == ST_ISSUE) && !f_out_valid) begin
        perf_stall <= sat_add(perf_stall, CNT_W'(1));
      end else begin
        perf_stall <= perf_stall;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vivo_pop_arbiter.sv
// Directed self-checking bench for vivo_pop_arbiter with a small registered-valid FIFO model.
module tb_vivo_pop_arbiter;
  localparam int NC = 4;
  localparam int OM = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NC-1:0]        c_req = '0;
  logic [NC-1:0][2:0]   c_req_elems = '0;
  logic [NC-1:0]        c_grant;
  logic [NC-1:0]        c_valid;
  logic [NC-1:0]        c_ready = '1;
  logic [OM-1:0][7:0]   c_data;
  logic [2:0]           c_num_elems;
  logic [2:0]           f_req_elems;
  logic                 f_out_ready;
  logic                 fv;
  logic [OM-1:0][7:0]   fd;
  logic [2:0]           fn;
  logic                 busy;
`ifdef VIVO_POP_ARB_PERF_EN
  logic                 perf_clr = 1'b0;
  logic [NC-1:0][15:0]  perf_elems;
  logic [15:0]          perf_stall;
`endif

  logic [7:0] q[$];
  int total = 0;
  int passed = 0;
  logic [31:0] held;

  vivo_pop_arbiter dut (
    .clk(clk), .rst_n(rst_n), .c_req(c_req), .c_req_elems(c_req_elems),
    .c_grant(c_grant), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_num_elems(c_num_elems), .f_req_elems(f_req_elems), .f_out_ready(f_out_ready),
    .f_out_valid(fv), .f_out_data(fd), .f_out_num_elems(fn), .busy(busy)
`ifdef VIVO_POP_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_elems(perf_elems), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: valid registered one cycle after a satisfiable request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv <= 1'b0; fd <= '0; fn <= '0;
    end else if (fv && f_out_ready) begin
      for (int i = 0; i < int'(fn); i++) void'(q.pop_front());
      fv <= 1'b0;
    end else if (f_req_elems != 3'd0 && q.size() >= int'(f_req_elems)) begin
      fv <= 1'b1;
      fn <= f_req_elems;
      for (int i = 0; i < OM; i++) fd[i] <= (i < int'(f_req_elems)) ? q[i] : 8'h00;
    end else begin
      fv <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_req = '0;
    c_ready = '1;
    tick();
    q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_grant", 32'(c_grant), 32'h0);
    check("rst_freq", 32'(f_req_elems), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_valid", 32'(c_valid), 32'h0);
    check("rst_fready", 32'(f_out_ready), 32'h0);
    rst_n = 1'b1;

    // Single consumer, 3 of 6 elements
    for (int i = 0; i < 6; i++) q.push_back(8'(8'h10 + i));
    c_req = 4'b0001; c_req_elems[0] = 3'd3;
    tick();
    check("t1_grant", 32'(c_grant), 32'h1);
    check("t1_freq", 32'(f_req_elems), 32'h3);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_novalid", 32'(c_valid), 32'h0);
    tick();
    check("t1_valid", 32'(c_valid), 32'h1);
    check("t1_num", 32'(c_num_elems), 32'h3);
    check("t1_data", 32'(c_data), 32'h00121110);
    check("t1_fready", 32'(f_out_ready), 32'h1);
    c_req = '0;
    tick();
    check("t1_grant_clr", 32'(c_grant), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);
    check("t1_left", 32'(q.size()), 32'd3);

    // Round robin, all request 1 element
    do_reset();
    for (int i = 0; i < 20; i++) q.push_back(8'(8'h20 + i));
    c_req = 4'b1111; c_req_elems = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("rr_grant%0d", t), 32'(c_grant), 32'(4'b0001 << (t % 4)));
      tick();
      check($sformatf("rr_data%0d", t), 32'(c_data), 32'(8'h20 + t));
      if (t == 4) c_req = '0;
      tick();
      check($sformatf("rr_arb%0d", t), 32'(c_grant), 32'h0);
    end

    // Insufficient data: waits in ISSUE until more elements arrive
    do_reset();
    q.push_back(8'h30); q.push_back(8'h31);
    c_req = 4'b0010; c_req_elems[1] = 3'd4;
    tick();
    check("t3_grant", 32'(c_grant), 32'h2);
    check("t3_freq", 32'(f_req_elems), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_busy", 32'(busy), 32'h1);
      check("t3_novalid", 32'(c_valid), 32'h0);
    end
    q.push_back(8'h32); q.push_back(8'h33);
    tick();
    check("t3_valid", 32'(c_valid), 32'h2);
    check("t3_num", 32'(c_num_elems), 32'h4);
    check("t3_data", 32'(c_data), 32'h33323130);
    c_req = '0;
    tick();
    check("t3_done", 32'(busy), 32'h0);

    // Consumer 2 backpressure for 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h40 + i));
    c_req = 4'b0100; c_req_elems[2] = 3'd2; c_ready = 4'b1011;
    tick();
    check("t4_grant", 32'(c_grant), 32'h4);
    tick();
    held = 32'(c_data);
    check("t4_data", held, 32'h00004140);
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", 32'(c_valid), 32'h4);
      check("t4_fready", 32'(f_out_ready), 32'h0);
      check("t4_hold", 32'(c_data), 32'h00004140);
      check("t4_freq", 32'(f_req_elems), 32'h2);
      if (i < 4) tick();
    end
    c_ready = 4'b1111; c_req = '0;
    #1;
    check("t4_fready_hi", 32'(f_out_ready), 32'h1);
    tick();
    check("t4_arb", 32'(busy), 32'h0);
    check("t4_grant_clr", 32'(c_grant), 32'h0);
    check("t4_left", 32'(q.size()), 32'd2);

    // Ineligible requests are skipped
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h50 + i));
    c_req = 4'b1001; c_req_elems[3] = 3'd0; c_req_elems[0] = 3'd5;
    tick();
    check("t5_none", 32'(c_grant), 32'h0);
    check("t5_nobusy", 32'(busy), 32'h0);
    c_req = 4'b1011; c_req_elems[1] = 3'd2;
    tick();
    check("t5_grant", 32'(c_grant), 32'h2);
    check("t5_freq", 32'(f_req_elems), 32'h2);
    tick();
    check("t5_valid", 32'(c_valid), 32'h2);
    c_req = '0;
    tick();

    // Reset mid-ISSUE
    do_reset();
    c_req = 4'b0001; c_req_elems[0] = 3'd4;
    tick();
    check("t6_busy", 32'(busy), 32'h1);
    tick();
`ifdef VIVO_POP_ARB_PERF_EN
    check("t6_stall", 32'(perf_stall), 32'h1);
`endif
    rst_n = 1'b0;
    #1;
    check("t6_grant", 32'(c_grant), 32'h0);
    check("t6_freq", 32'(f_req_elems), 32'h0);
    check("t6_busy0", 32'(busy), 32'h0);
    check("t6_valid", 32'(c_valid), 32'h0);
`ifdef VIVO_POP_ARB_PERF_EN
    check("t6_perf_stall0", 32'(perf_stall), 32'h0);
    check("t6_perf_elems0", 32'(perf_elems[0]), 32'h0);
`endif
    c_req = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vivo_pop_arbiter.md
Name: vivo_pop_arbiter

Overview:
- Shares the single pop port of a vivo_fifo between NUM_CONS consumers, each requesting a variable element count per transaction.
- Round-robin arbitration with a per-grant FSM that holds the FIFO request stable until the FIFO's registered out_valid/out_ready handshake completes.
- Sits between vivo_fifo (pop side) and the consumer engines.

Parameters:
- NUM_CONS, 4, number of consumers (2..8)
- ELEM_WIDTH, 8, element width in bits
- OUT_ELEMS_MAX, 4, max elements per pop; must equal the FIFO's OUT_ELEMS_MAX
- CNT_W, 16, width of the perf counters (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- c_req  in  NUM_CONS  per-consumer pop request
- c_req_elems  in  NUM_CONS x $clog2(OUT_ELEMS_MAX+1)  elements requested, per consumer
- c_grant  out  NUM_CONS  one-hot registered grant
- c_valid  out  NUM_CONS  data valid toward the granted consumer
- c_ready  in  NUM_CONS  consumer accepts data
- c_data  out  OUT_ELEMS_MAX x ELEM_WIDTH  broadcast data (f_out_data)
- c_num_elems  out  $clog2(OUT_ELEMS_MAX+1)  broadcast count (f_out_num_elems)
- f_req_elems  out  $clog2(OUT_ELEMS_MAX+1)  drives FIFO out_req_elems
- f_out_ready  out  1  drives FIFO out_ready
- f_out_valid  in  1  FIFO out_valid
- f_out_data  in  OUT_ELEMS_MAX x ELEM_WIDTH  FIFO out_data
- f_out_num_elems  in  $clog2(OUT_ELEMS_MAX+1)  FIFO out_num_elems
- busy  out  1  high in ISSUE state

Behaviour:
- Reset: state=ARB, rr_ptr=0, c_grant=0, latched elems=0. Outputs c_valid=0, f_req_elems=0, f_out_ready=0, busy=0.
- Eligible consumer: c_req[i]=1 and 1 <= c_req_elems[i] <= OUT_ELEMS_MAX. Consumers with 0 or an out-of-range value are ignored.
- ARB state:
  - f_req_elems=0.
  - Select the first eligible consumer scanning rr_ptr, rr_ptr+1, ... modulo NUM_CONS.
  - If one is found: register c_grant (one-hot) and g_elems=c_req_elems[g]; go to ISSUE.
  - If none: stay in ARB.
- ISSUE state:
  - f_req_elems=g_elems, held constant for the whole state.
  - c_valid[g]=f_out_valid; other c_valid bits are 0.
  - f_out_ready=c_ready[g] & f_out_valid.
  - Handshake cycle (f_out_valid & c_ready[g]): next state ARB, c_grant cleared, rr_ptr=(g+1) mod NUM_CONS.
- Latency: c_req at cycle 0 -> c_grant and f_req_elems at cycle 1 -> FIFO valid at cycle 2 (if enough data) -> handshake at cycle 2 at the earliest.
- Throughput: at best one pop per 3 cycles. The ARB cycle, with f_req_elems=0, guarantees the FIFO's registered valid is cleared before a new request is issued.
- Insufficient data: the FIFO never raises valid, so the arbiter stays in ISSUE indefinitely. No pre-emption and no timeout.
- Protocol rule: a granted consumer keeps c_req high until handshake. The arbiter does not re-sample c_req or c_req_elems in ISSUE; a dropped request does not abort the grant.
- Consumer stalls (c_ready=0 with valid=1) hold state and data.
- c_ready from non-granted consumers is ignored.
- Reset asserted mid-transaction returns all state to reset values immediately; no partial pop is reported.

Optional Feature:
- Macro: VIVO_POP_ARB_PERF_EN.
- Enabled adds:
  - Output perf_elems: NUM_CONS x CNT_W. Element count delivered per consumer; adds c_num_elems on each handshake; saturates at all-ones.
  - Output perf_stall: CNT_W. Counts ISSUE cycles with f_out_valid=0; saturates.
  - Input perf_clr: 1 bit. Synchronously zeroes all perf counters; clear wins over a same-cycle increment.
  - All counters reset to 0.
- Disabled: these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single consumer: FIFO holds 6 elems, c_req[0]=1 with elems=3, c_ready=1.
  - Required: c_grant=0001 at cycle 1, f_req_elems=3, c_valid[0] at cycle 2, c_num_elems=3, data in push order, FIFO left with 3.
- Round-robin: all 4 consumers request elems=1 continuously, FIFO full.
  - Required: grant order 0,1,2,3,0; each grant exactly once per 4 transactions.
- Insufficient data: FIFO holds 2, consumer 1 requests 4.
  - Required: stays in ISSUE with busy=1 and c_valid=0. After 2 more elements are pushed, valid appears and num_elems=4.
- Consumer backpressure: c_ready[2]=0 for 5 cycles after valid.
  - Required: f_out_ready=0, data and f_req_elems stable, handshake on the cycle c_ready rises, then ARB.
- Ineligible requests: c_req[3]=1 with elems=0, and c_req[0]=1 with elems=OUT_ELEMS_MAX+1 (if representable).
  - Required: neither is granted; consumer 1 with elems=2 is granted.
- Reset mid-ISSUE.
  - Required: c_grant=0, f_req_elems=0, busy=0 immediately. Perf counters are 0 when VIVO_POP_ARB_PERF_EN is defined.
